// File: rtl/hyper_read_burst_ctrl.sv
// Sequences one HyperBus read burst: latency wait, capture enable, FIFO pop and forward to uDMA RX.
// Latency: READ entered latency_i cycles after start; data path FIFO->RX is combinational; done_o one cycle after last pop.
// Backpressure: fifo_ready_o follows rx_ready_i while reading, so RX stalls hold data in the capture FIFO.
// Optional RWDS-stall timeout enabled by defining HYPER_RD_TIMEOUT_EN.
module hyper_read_burst_ctrl #(
  parameter int LEN_W = 16,
  parameter int TO_W  = 16
) (
  input  logic             clk0,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [7:0]       latency_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic             abort_i,
  output logic             read_clk_en_o,
  input  logic             fifo_valid_i,
  input  logic [31:0]      fifo_data_i,
  output logic             fifo_ready_o,
  output logic             rx_valid_o,
  output logic [31:0]      rx_data_o,
  input  logic             rx_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LAT = 2'd1,
    READ     = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       lat_cnt_q, lat_cnt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             timeout_hit;

`ifdef HYPER_RD_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;

  // Stall counter: zero outside READ (so it is clear on entry) and on every valid beat.
  always_ff @(posedge clk0) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (state_q != READ || fifo_valid_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_hit = (state_q == READ) && !fifo_valid_i &&
                       (timeout_i != '0) && (to_cnt_q == timeout_i);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign timeout_hit    = 1'b0;
`endif

  // State and burst bookkeeping registers.
  always_ff @(posedge clk0) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  // Next-state and outputs; abort masks the data handshake so no beat is lost in that cycle.
  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    err_d         = err_q;
    read_clk_en_o = 1'b0;
    fifo_ready_o  = 1'b0;
    rx_valid_o    = 1'b0;
    rx_data_o     = '0;
    busy_o        = (state_q != IDLE);
    done_o        = 1'b0;
    error_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d     = burst_len_i;
          lat_cnt_d = latency_i;
          cnt_d     = '0;
          err_d     = 1'b0;
          if (burst_len_i == '0) begin
            state_d = FINISH;
          end else if (latency_i == 8'd0) begin
            state_d = READ;
          end else begin
            state_d = WAIT_LAT;
          end
        end
      end

      WAIT_LAT: begin
        if (abort_i) begin
          state_d = FINISH;
        end else if (lat_cnt_q == 8'd1) begin
          state_d = READ;
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end

      READ: begin
        // Capture clock stays on through the final pop since it also clocks the FIFO read side.
        read_clk_en_o = 1'b1;
        rx_data_o     = fifo_data_i;
        if (abort_i) begin
          state_d = FINISH;
        end else begin
          rx_valid_o   = fifo_valid_i;
          fifo_ready_o = rx_ready_i;
          if (fifo_valid_i && rx_ready_i) begin
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              state_d = FINISH;
            end
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        done_o  = 1'b1;
        error_o = err_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hyper_read_burst_ctrl.sv
// Bench for hyper_read_burst_ctrl: per-cycle vector table plus timeout/stall sequences.
// Inputs change on the falling edge; outputs are compared 1 ns later, away from the rising edge.
// Optional timeout checks track HYPER_RD_TIMEOUT_EN.
module tb_hyper_read_burst_ctrl;

  logic        clk0 = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] burst_len_i;
  logic [7:0]  latency_i;
  logic [15:0] timeout_i;
  logic        abort_i;
  logic        read_clk_en_o;
  logic        fifo_valid_i;
  logic [31:0] fifo_data_i;
  logic        fifo_ready_o;
  logic        rx_valid_o;
  logic [31:0] rx_data_o;
  logic        rx_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int total = 0;
  int bad   = 0;

  hyper_read_burst_ctrl #(.LEN_W(16), .TO_W(16)) dut (
    .clk0          (clk0),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .burst_len_i   (burst_len_i),
    .latency_i     (latency_i),
    .timeout_i     (timeout_i),
    .abort_i       (abort_i),
    .read_clk_en_o (read_clk_en_o),
    .fifo_valid_i  (fifo_valid_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_ready_o  (fifo_ready_o),
    .rx_valid_o    (rx_valid_o),
    .rx_data_o     (rx_data_o),
    .rx_ready_i    (rx_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    string       tag;
    logic        rst_n, start;
    logic [15:0] len;
    logic [7:0]  lat;
    logic        abort, fv;
    logic [31:0] fd;
    logic        rr;
    logic        e_clk, e_fr, e_rv;
    logic [31:0] e_rd;
    logic        e_busy, e_done, e_err;
  } vec_t;

  vec_t vec[$];

  task automatic row(input string tag, input logic rst_n, input logic st, input logic [15:0] len,
                     input logic [7:0] lat, input logic ab, input logic fv, input logic [31:0] fd,
                     input logic rr, input logic eclk, input logic efr, input logic erv,
                     input logic [31:0] erd, input logic ebusy, input logic edone, input logic eerr);
    vec_t v;
    v.tag = tag; v.rst_n = rst_n; v.start = st; v.len = len; v.lat = lat; v.abort = ab;
    v.fv = fv; v.fd = fd; v.rr = rr; v.e_clk = eclk; v.e_fr = efr; v.e_rv = erv;
    v.e_rd = erd; v.e_busy = ebusy; v.e_done = edone; v.e_err = eerr;
    vec.push_back(v);
  endtask

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", what, act, exp);
    end
  endtask

  task automatic drive_idle();
    start_i = 0; burst_len_i = 0; latency_i = 0; abort_i = 0;
    fifo_valid_i = 0; fifo_data_i = 0; rx_ready_i = 0;
  endtask

  initial begin
    rst_ni = 0;
    timeout_i = 16'd10;
    drive_idle();

    //   tag        rst st len lat ab fv fd            rr | clk fr rv rd            bsy dn er
    // normal burst len=4 lat=3, plus start during READ ignored
    row("n_rst",     1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("n_idlefv",  1, 0, 0, 0, 0, 1, 32'hAAAA5555, 1,   0, 0, 0, 32'h0,        0, 0, 0);
    row("n_start",   1, 1, 4, 3, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("n_lat3",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        1, 0, 0);
    row("n_lat2",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        1, 0, 0);
    row("n_lat1",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        1, 0, 0);
    row("n_d0",      1, 0, 0, 0, 0, 1, 32'hD0D0_0000, 1,  1, 1, 1, 32'hD0D0_0000, 1, 0, 0);
    row("n_d1_st",   1, 1, 0, 0, 0, 1, 32'hD1D1_1111, 1,  1, 1, 1, 32'hD1D1_1111, 1, 0, 0);
    row("n_d2",      1, 0, 0, 0, 0, 1, 32'hD2D2_2222, 1,  1, 1, 1, 32'hD2D2_2222, 1, 0, 0);
    row("n_d3",      1, 0, 0, 0, 0, 1, 32'hD3D3_3333, 1,  1, 1, 1, 32'hD3D3_3333, 1, 0, 0);
    row("n_fin",     1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1,  0, 0, 0, 32'h0,        1, 1, 0);
    row("n_idle",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    // backpressure len=3 lat=0, rx_ready toggling
    row("b_start",   1, 1, 3, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("b_e0",      1, 0, 0, 0, 0, 1, 32'hE000_0000, 1,  1, 1, 1, 32'hE000_0000, 1, 0, 0);
    row("b_stall1",  1, 0, 0, 0, 0, 1, 32'hE111_1111, 0,  1, 0, 1, 32'hE111_1111, 1, 0, 0);
    row("b_e1",      1, 0, 0, 0, 0, 1, 32'hE111_1111, 1,  1, 1, 1, 32'hE111_1111, 1, 0, 0);
    row("b_stall2",  1, 0, 0, 0, 0, 1, 32'hE222_2222, 0,  1, 0, 1, 32'hE222_2222, 1, 0, 0);
    row("b_e2",      1, 0, 0, 0, 0, 1, 32'hE222_2222, 1,  1, 1, 1, 32'hE222_2222, 1, 0, 0);
    row("b_fin",     1, 0, 0, 0, 0, 1, 32'h0,        0,   0, 0, 0, 32'h0,        1, 1, 0);
    row("b_idle",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    // zero length
    row("z_start",   1, 1, 0, 5, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("z_fin",     1, 0, 0, 0, 0, 1, 32'h1234,     1,   0, 0, 0, 32'h0,        1, 1, 0);
    row("z_idle",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    // abort after 2 transfers, len=8 lat=1
    row("a_start",   1, 1, 8, 1, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("a_lat1fv",  1, 0, 0, 0, 0, 1, 32'h5555_5555, 1,  0, 0, 0, 32'h0,        1, 0, 0);
    row("a_f0",      1, 0, 0, 0, 0, 1, 32'hF000_0000, 1,  1, 1, 1, 32'hF000_0000, 1, 0, 0);
    row("a_novld",   1, 0, 0, 0, 0, 0, 32'h0,        1,   1, 1, 0, 32'h0,        1, 0, 0);
    row("a_f1",      1, 0, 0, 0, 0, 1, 32'hF111_1111, 1,  1, 1, 1, 32'hF111_1111, 1, 0, 0);
    row("a_abort",   1, 0, 0, 0, 1, 1, 32'hF222_2222, 1,  1, 0, 0, 32'h0,        1, 0, 0);
    row("a_fin",     1, 0, 0, 0, 0, 1, 32'hF222_2222, 1,  0, 0, 0, 32'h0,        1, 1, 0);
    row("a_idleab",  1, 0, 0, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("a_stab",    1, 1, 1, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("a_g0",      1, 0, 0, 0, 0, 1, 32'h6060_6060, 1,  1, 1, 1, 32'h6060_6060, 1, 0, 0);
    row("a_finab",   1, 0, 0, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0,        1, 1, 0);
    row("a_idle",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    // abort during latency wait
    row("w_start",   1, 1, 2, 4, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("w_abort",   1, 0, 0, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0,        1, 0, 0);
    row("w_fin",     1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        1, 1, 0);
    row("w_idle",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    // reset mid-READ, then a fresh one-word burst
    row("r_start",   1, 1, 4, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("r_h0",      1, 0, 0, 0, 0, 1, 32'h7000_0000, 1,  1, 1, 1, 32'h7000_0000, 1, 0, 0);
    row("r_rstlow",  0, 0, 0, 0, 0, 1, 32'h7111_1111, 1,  1, 1, 1, 32'h7111_1111, 1, 0, 0);
    row("r_after",   1, 0, 0, 0, 0, 1, 32'h7222_2222, 1,  0, 0, 0, 32'h0,        0, 0, 0);
    row("r_start2",  1, 1, 1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);
    row("r_k0",      1, 0, 0, 0, 0, 1, 32'h8888_8888, 1,  1, 1, 1, 32'h8888_8888, 1, 0, 0);
    row("r_fin",     1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        1, 1, 0);
    row("r_idle",    1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0,        0, 0, 0);

    repeat (2) @(posedge clk0);

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk0);
      rst_ni = vec[i].rst_n; start_i = vec[i].start; burst_len_i = vec[i].len;
      latency_i = vec[i].lat; abort_i = vec[i].abort; fifo_valid_i = vec[i].fv;
      fifo_data_i = vec[i].fd; rx_ready_i = vec[i].rr;
      #1;
      check({vec[i].tag, " read_clk_en"}, 32'(read_clk_en_o), 32'(vec[i].e_clk));
      check({vec[i].tag, " fifo_ready"},  32'(fifo_ready_o),  32'(vec[i].e_fr));
      check({vec[i].tag, " rx_valid"},    32'(rx_valid_o),    32'(vec[i].e_rv));
      if (vec[i].e_rv) check({vec[i].tag, " rx_data"}, rx_data_o, vec[i].e_rd);
      check({vec[i].tag, " busy"},        32'(busy_o),        32'(vec[i].e_busy));
      check({vec[i].tag, " done"},        32'(done_o),        32'(vec[i].e_done));
      check({vec[i].tag, " error"},       32'(error_o),       32'(vec[i].e_err));
    end

    // Stall sequence: len=4, one word, then FIFO goes empty.
    @(negedge clk0);
    drive_idle(); rst_ni = 1; start_i = 1; burst_len_i = 4;
    @(negedge clk0);
    drive_idle(); fifo_valid_i = 1; fifo_data_i = 32'h9999_0000; rx_ready_i = 1;
    #1 check("stall first_pop", 32'(rx_valid_o & fifo_ready_o), 32'd1);
    begin
      int gap;
      bit seen;
      gap = 0;
      seen = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
        @(negedge clk0);
        drive_idle(); rx_ready_i = 1;
        #1;
        if (done_o) begin
          seen = 1;
          gap = c;
        end
      end
`ifdef HYPER_RD_TIMEOUT_EN
      check("timeout done_seen", 32'(seen), 32'd1);
      check("timeout error", 32'(error_o), 32'd1);
      total++;
      if (gap < 10 || gap > 12) begin
        bad++;
        $display("FAIL timeout gap actual=%0d required=10..12", gap);
      end
      @(negedge clk0);
      drive_idle();
      #1 check("timeout idle busy", 32'(busy_o), 32'd0);
`else
      check("no_timeout done_seen", 32'(seen), 32'd0);
      check("no_timeout busy", 32'(busy_o), 32'd1);
      check("no_timeout clk_en", 32'(read_clk_en_o), 32'd1);
      @(negedge clk0);
      drive_idle(); abort_i = 1;
      @(negedge clk0);
      drive_idle();
      #1 check("stall abort done", 32'(done_o), 32'd1);
      check("stall abort error", 32'(error_o), 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
